// File: rtl/voice_allocator_pkg.sv
// Shared synth constants: sample-rate scaling, octave-10 pitch table and the allocator FSM states.
package voice_allocator_pkg;

  localparam int BITDEPTH    = 8;
  localparam int BITFRACTION = 12;
  localparam int PITCH_W     = BITDEPTH + BITFRACTION;
  localparam int SAMPLEFREQ  = 31250;
  localparam int TABLE_W     = 21;

  typedef logic [6:0] note_t;

  // Increments of notes 120..131: round(f * 2^21 / SAMPLEFREQ); lower octaves shift these down.
  localparam logic [TABLE_W-1:0] PITCH_TABLE [12] = '{
    21'd561837, 21'd595245, 21'd630640, 21'd668140,
    21'd707870, 21'd749962, 21'd794557, 21'd841804,
    21'd891860, 21'd944893, 21'd1001079, 21'd1060606
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between an event source (master) and the voice allocator (slave).
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic  ev_valid;
  logic  ev_ready;
  logic  ev_on;
  note_t ev_note;

  modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_note_pitch_lut.sv
// Combinational MIDI note -> pitch increment: top-octave table entry shifted down by octave.
module note_pitch_lut
  import voice_allocator_pkg::*;
#(
  parameter int PITCH_W = voice_allocator_pkg::PITCH_W
) (
  input  note_t              note_i,
  output logic [PITCH_W-1:0] pitch_o
);

  logic [3:0]         octave;
  logic [3:0]         semi;
  logic [3:0]         shift;
  logic [TABLE_W-1:0] base;

  always_comb begin
    octave  = 4'(note_i / 7'd12);
    semi    = 4'(note_i % 7'd12);
    // Table sits at octave 10 (notes 120..131), so lower octaves divide by 2^(10-octave).
    shift   = 4'd10 - octave;
    base    = PITCH_TABLE[semi];
    pitch_o = PITCH_W'(base >> shift);
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan over voices, retrigger/free/oldest-steal selection.
// Optional VOICE_ALLOC_RETRIG_EN: retriggered/stolen voices drop gate until the next sample_tick.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PITCH_W    = voice_allocator_pkg::PITCH_W,
  parameter int STAMP_W    = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sample_tick,
  input  logic                          panic,
  voice_allocator_if.slave              ev,
  output logic [NUM_VOICES-1:0]         voice_gate,
  output logic [7*NUM_VOICES-1:0]       voice_note,
  output logic [PITCH_W*NUM_VOICES-1:0] voice_pitch,
  output logic                          steal,
  output logic                          busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e        state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ev_on_q, ev_on_d;
  note_t               ev_note_q, ev_note_d;
  logic                hit_found_q, hit_found_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                free_found_q, free_found_d;
  logic [IDX_W-1:0]    free_idx_q, free_idx_d;
  logic                old_found_q, old_found_d;
  logic [IDX_W-1:0]    old_idx_q, old_idx_d;
  logic [STAMP_W-1:0]  old_age_q, old_age_d;
  logic [STAMP_W-1:0]  seq_q, seq_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  note_t               note_q  [NUM_VOICES];
  note_t               note_d  [NUM_VOICES];
  logic [PITCH_W-1:0]  pitch_q [NUM_VOICES];
  logic [PITCH_W-1:0]  pitch_d [NUM_VOICES];
  logic [STAMP_W-1:0]  stamp_q [NUM_VOICES];
  logic [STAMP_W-1:0]  stamp_d [NUM_VOICES];
  logic                steal_q, steal_d;
  logic                rdy_q, rdy_d;

  logic [NUM_VOICES-1:0] active;
  logic [STAMP_W-1:0]    scan_age;
  logic [IDX_W-1:0]      sel_idx;
  logic [PITCH_W-1:0]    lut_pitch;
  logic                  accept;

`ifdef VOICE_ALLOC_RETRIG_EN
  logic [NUM_VOICES-1:0] pend_q, pend_d;
  logic                  sel_gated;
  // A voice waiting for its gate to come back still owns its note.
  assign active = gate_q | pend_q;
`else
  logic unused_tick;
  assign unused_tick = sample_tick;
  assign active      = gate_q;
`endif

  note_pitch_lut #(.PITCH_W(PITCH_W)) u_lut (
    .note_i (ev_note_q),
    .pitch_o(lut_pitch)
  );

  assign ev.ev_ready = (state_q == IDLE) && rdy_q && !panic;
  assign accept      = ev.ev_valid && ev.ev_ready;
  assign scan_age    = seq_q - stamp_q[idx_q];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ev_on_d      = ev_on_q;
    ev_note_d    = ev_note_q;
    hit_found_d  = hit_found_q;
    hit_idx_d    = hit_idx_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    old_found_d  = old_found_q;
    old_idx_d    = old_idx_q;
    old_age_d    = old_age_q;
    seq_d        = seq_q;
    gate_d       = gate_q;
    note_d       = note_q;
    pitch_d      = pitch_q;
    stamp_d      = stamp_q;
    steal_d      = 1'b0;
    rdy_d        = 1'b1;
    sel_idx      = '0;
`ifdef VOICE_ALLOC_RETRIG_EN
    pend_d       = pend_q;
    sel_gated    = 1'b0;
    if (sample_tick) begin
      gate_d = gate_q | pend_q;
      pend_d = '0;
    end
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          ev_on_d      = ev.ev_on;
          ev_note_d    = ev.ev_note;
          idx_d        = '0;
          hit_found_d  = 1'b0;
          free_found_d = 1'b0;
          old_found_d  = 1'b0;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        if (active[idx_q]) begin
          if (!hit_found_q && note_q[idx_q] == ev_note_q) begin
            hit_found_d = 1'b1;
            hit_idx_d   = idx_q;
          end
          // Strictly greater keeps the lowest index on equal ages.
          if (!old_found_q || scan_age > old_age_q) begin
            old_found_d = 1'b1;
            old_idx_d   = idx_q;
            old_age_d   = scan_age;
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end

      COMMIT: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (hit_found_q) begin
            sel_idx = hit_idx_q;
`ifdef VOICE_ALLOC_RETRIG_EN
            sel_gated = 1'b1;
`endif
          end else if (free_found_q) begin
            sel_idx = free_idx_q;
          end else begin
            sel_idx = old_idx_q;
            steal_d = 1'b1;
`ifdef VOICE_ALLOC_RETRIG_EN
            sel_gated = 1'b1;
`endif
          end
          note_d[sel_idx]  = ev_note_q;
          pitch_d[sel_idx] = lut_pitch;
          stamp_d[sel_idx] = seq_q;
          seq_d            = seq_q + STAMP_W'(1);
`ifdef VOICE_ALLOC_RETRIG_EN
          gate_d[sel_idx]  = !sel_gated;
          pend_d[sel_idx]  = sel_gated;
`else
          gate_d[sel_idx]  = 1'b1;
`endif
        end else if (hit_found_q) begin
          gate_d[hit_idx_q] = 1'b0;
`ifdef VOICE_ALLOC_RETRIG_EN
          pend_d[hit_idx_q] = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // Panic wins over everything, including an event that is just committing.
    if (panic) begin
      state_d = IDLE;
      gate_d  = '0;
      note_d  = note_q;
      pitch_d = pitch_q;
      stamp_d = stamp_q;
      seq_d   = seq_q;
      steal_d = 1'b0;
`ifdef VOICE_ALLOC_RETRIG_EN
      pend_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      hit_found_q  <= 1'b0;
      hit_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      old_found_q  <= 1'b0;
      old_idx_q    <= '0;
      old_age_q    <= '0;
      seq_q        <= '0;
      gate_q       <= '0;
      steal_q      <= 1'b0;
      rdy_q        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i]  <= '0;
        pitch_q[i] <= '0;
        stamp_q[i] <= '0;
      end
`ifdef VOICE_ALLOC_RETRIG_EN
      pend_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ev_on_q      <= ev_on_d;
      ev_note_q    <= ev_note_d;
      hit_found_q  <= hit_found_d;
      hit_idx_q    <= hit_idx_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      old_found_q  <= old_found_d;
      old_idx_q    <= old_idx_d;
      old_age_q    <= old_age_d;
      seq_q        <= seq_d;
      gate_q       <= gate_d;
      steal_q      <= steal_d;
      rdy_q        <= rdy_d;
      note_q       <= note_d;
      pitch_q      <= pitch_d;
      stamp_q      <= stamp_d;
`ifdef VOICE_ALLOC_RETRIG_EN
      pend_q       <= pend_d;
`endif
    end
  end

  always_comb begin
    voice_note  = '0;
    voice_pitch = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7]              = note_q[i];
      voice_pitch[PITCH_W*i +: PITCH_W] = pitch_q[i];
    end
  end

  assign voice_gate = gate_q;
  assign steal      = steal_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator plus a long note-on/off run checked against a behavioural model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int PW = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sample_tick = 1'b0;
  logic panic = 1'b0;
  logic [NV-1:0]    voice_gate;
  logic [7*NV-1:0]  voice_note;
  logic [PW*NV-1:0] voice_pitch;
  logic steal;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  voice_allocator_if ev_if ();

  voice_allocator #(.NUM_VOICES(NV), .PITCH_W(PW), .STAMP_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sample_tick(sample_tick),
    .panic      (panic),
    .ev         (ev_if.slave),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_pitch(voice_pitch),
    .steal      (steal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_act  [NV];
  bit m_used [NV];
  int m_note [NV];
  int m_stamp[NV];
  int m_seq;
  bit m_steal;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pitch(input int n);
    real f;
    real inc;
    int  base;
    f    = 440.0 * (2.0 ** ((real'(120 + n % 12) - 69.0) / 12.0));
    inc  = f * 2097152.0 / 31250.0;
    base = int'(inc);
    return (base >> (10 - n / 12)) & 32'hFFFFF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    ev_if.ev_valid = 1'b0;
    panic = 1'b0;
    sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ev_if.ev_ready, 0);
    check("rst_gate", voice_gate, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", ev_if.ev_ready, 1);
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_used[i] = 0; m_note[i] = 0; m_stamp[i] = 0;
    end
    m_seq = 0;
  endtask

  task automatic send(input bit on, input int note, output bit stl);
    int t;
    @(negedge clk);
    t = 0;
    while (ev_if.ev_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", ev_if.ev_ready, 1);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = 7'(note);
    @(posedge clk);
    #1;
    ev_if.ev_valid = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_wait", busy, 0);
    stl = steal;
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic model_step(input bit on, input int n);
    int sel;
    int bage;
    int age;
    sel = -1;
    m_steal = 0;
    for (int i = 0; i < NV; i++)
      if (sel < 0 && m_act[i] && m_note[i] == n) sel = i;
    if (!on) begin
      if (sel >= 0) m_act[sel] = 0;
      return;
    end
    if (sel < 0)
      for (int i = 0; i < NV; i++)
        if (sel < 0 && !m_act[i]) sel = i;
    if (sel < 0) begin
      bage = -1;
      for (int i = 0; i < NV; i++) begin
        age = (m_seq - m_stamp[i]) & 255;
        if (age > bage) begin sel = i; bage = age; end
      end
      m_steal = 1;
    end
    m_act[sel] = 1; m_used[sel] = 1; m_note[sel] = n; m_stamp[sel] = m_seq;
    m_seq = (m_seq + 1) & 255;
  endtask

  task automatic compare_model(input bit stl);
    logic [NV-1:0]   g;
    logic [7*NV-1:0] nv;
    g = '0;
    nv = '0;
    for (int i = 0; i < NV; i++) begin
      g[i] = m_act[i];
      nv[7*i +: 7] = 7'(m_note[i]);
    end
    check("rnd_gate", voice_gate, g);
    check("rnd_note", voice_note, nv);
    check("rnd_steal", stl, m_steal);
    for (int i = 0; i < NV; i++)
      if (m_used[i]) check("rnd_pitch", voice_pitch[PW*i +: PW], ref_pitch(m_note[i]));
  endtask

  initial begin
    bit stl;
    int low;
    int n;
    logic [7*NV-1:0] note_snap;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;

    // Single note-on: latency and first-voice placement
    do_reset();
    check("rst_note", voice_note, 0);
    check("rst_pitch", voice_pitch, 0);
    check("rst_steal", steal, 0);
    @(negedge clk);
    ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 7'd60;
    check("t1_ready_pre", ev_if.ev_ready, 1);
    @(posedge clk);
    #1;
    ev_if.ev_valid = 1'b0;
    low = 0;
    while (ev_if.ev_ready === 1'b0 && low < 20) begin
      check("t1_gate_early", voice_gate, 0);
      low++;
      @(posedge clk);
      #1;
    end
    check("t1_ready_low_cycles", low, NV + 1);
    check("t1_gate", voice_gate, 4'b0001);
    check("t1_note0", voice_note[6:0], 60);
    check("t1_pitch0", voice_pitch[19:0], 17557);

    // Fill all voices, then steal the oldest
    do_reset();
    send(1, 60, stl);
    send(1, 62, stl);
    send(1, 64, stl);
    send(1, 65, stl);
    check("t2_full", voice_gate, 4'b1111);
    check("t2_no_steal", stl, 0);
    send(1, 67, stl);
    check("t2_steal", stl, 1);
    check("t2_note0", voice_note[6:0], 67);
    check("t2_pitch0", voice_pitch[19:0], 26306);
    check("t2_pitch1", voice_pitch[39:20], 19707);
`ifdef VOICE_ALLOC_RETRIG_EN
    check("t2_gate_low", voice_gate, 4'b1110);
    tick_pulse();
    check("t2_gate_back", voice_gate, 4'b1111);
`else
    check("t2_gate", voice_gate, 4'b1111);
    @(posedge clk);
    #1;
    check("t2_steal_once", steal, 0);
`endif

    // Retrigger of the same note
    do_reset();
    send(1, 64, stl);
    send(1, 64, stl);
    check("t3_steal", stl, 0);
    check("t3_note0", voice_note[6:0], 64);
    check("t3_pitch0", voice_pitch[19:0], 22120);
`ifdef VOICE_ALLOC_RETRIG_EN
    check("t3_gate_low", voice_gate, 4'b0000);
    @(posedge clk);
    #1;
    check("t3_gate_hold", voice_gate, 4'b0000);
    tick_pulse();
    check("t3_gate_back", voice_gate, 4'b0001);
`else
    check("t3_gate", voice_gate, 4'b0001);
`endif

    // Note-off miss and hit
    send(1, 62, stl);
    check("t4_gate2", voice_gate, 4'b0011);
    note_snap = voice_note;
    send(0, 70, stl);
    check("t4_miss_gate", voice_gate, 4'b0011);
    check("t4_miss_note", voice_note, note_snap);
    send(0, 62, stl);
    check("t4_off_gate", voice_gate, 4'b0001);
    check("t4_off_note1", voice_note[13:7], 62);
    check("t4_off_pitch1", voice_pitch[39:20], 19707);

    // Panic during SCAN
    @(negedge clk);
    ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 7'd65;
    @(posedge clk);
    #1;
    ev_if.ev_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_in_scan", busy, 1);
    @(negedge clk);
    panic = 1'b1;
    #1;
    check("t5_ready_panic", ev_if.ev_ready, 0);
    @(posedge clk);
    #1;
    check("t5_gate", voice_gate, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    panic = 1'b0;
    #1;
    check("t5_ready_after", ev_if.ev_ready, 1);
    repeat (NV + 2) @(posedge clk);
    #1;
    check("t5_dropped_note1", voice_note[13:7], 62);
    check("t5_note0", voice_note[6:0], 64);
    check("t5_pitch0", voice_pitch[19:0], 22120);
    check("t5_gate_stay", voice_gate, 0);

    // Asynchronous reset mid-event
    @(negedge clk);
    ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 7'd60;
    @(posedge clk);
    #1;
    ev_if.ev_valid = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_ready", ev_if.ev_ready, 0);
    check("t6_note", voice_note, 0);
    check("t6_pitch", voice_pitch, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ready_after", ev_if.ev_ready, 1);

    // Long run: seq wraps past 255, steals must track true age
    do_reset();
    for (int i = 0; i < 300; i++) begin
      n = 30 + int'($urandom_range(0, 39));
      model_step(1, n);
      send(1, n, stl);
      tick_pulse();
      compare_model(stl);
      n = 30 + int'($urandom_range(0, 39));
      model_step(0, n);
      send(0, n, stl);
      tick_pulse();
      compare_model(stl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
